udp_tx_arbiter: RTL

Round-robin arbiter that shares one UDP transmit path (header plus 8-bit payload stream) between `NUM_PORTS` requesters. Each requester presents a UDP TX header followed by its payload. The arbiter grants one requester per packet, registers its header toward the UDP stack, and then locks the payload mux to that requester until its `tlast` beat. It sits between reply generators (echo, ID-acknowledge, status responders) and the single UDP TX header/payload interface pair of the UDP stack. It also checks each forwarded payload length against the header `length` field.

---
 rtl/udp_tx_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of one UDP TX header/payload path.
// Header is registered per grant; payload is a mux locked until tlast.
module udp_tx_arbiter #(
  parameter  int NUM_PORTS   = 2,
  localparam int GRANT_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [NUM_PORTS-1:0]        in_hdr_valid,
  output logic [NUM_PORTS-1:0]        in_hdr_ready,
  input  logic [NUM_PORTS-1:0][5:0]   in_dscp,
  input  logic [NUM_PORTS-1:0][1:0]   in_ecn,
  input  logic [NUM_PORTS-1:0][7:0]   in_ttl,
  input  logic [NUM_PORTS-1:0][31:0]  in_src_ip,
  input  logic [NUM_PORTS-1:0][31:0]  in_dst_ip,
  input  logic [NUM_PORTS-1:0][15:0]  in_src_port,
  input  logic [NUM_PORTS-1:0][15:0]  in_dst_port,
  input  logic [NUM_PORTS-1:0][15:0]  in_length,
  input  logic [NUM_PORTS-1:0][15:0]  in_checksum,

  input  logic [NUM_PORTS-1:0]        in_tvalid,
  output logic [NUM_PORTS-1:0]        in_tready,
  input  logic [NUM_PORTS-1:0][7:0]   in_tdata,
  input  logic [NUM_PORTS-1:0]        in_tlast,
  input  logic [NUM_PORTS-1:0]        in_tuser,

  output logic                        out_hdr_valid,
  input  logic                        out_hdr_ready,
  output logic [5:0]                  out_dscp,
  output logic [1:0]                  out_ecn,
  output logic [7:0]                  out_ttl,
  output logic [31:0]                 out_src_ip,
  output logic [31:0]                 out_dst_ip,
  output logic [15:0]                 out_src_port,
  output logic [15:0]                 out_dst_port,
  output logic [15:0]                 out_length,
  output logic [15:0]                 out_checksum,

  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic [7:0]                  out_tdata,
  output logic                        out_tlast,
  output logic                        out_tuser,

  output logic [GRANT_WIDTH-1:0]      grant,
  output logic                        busy,
  output logic                        length_error,
  output logic [GRANT_WIDTH-1:0]      error_port
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]             state;
  logic [GRANT_WIDTH-1:0] rr_ptr;
  logic [15:0]            byte_count;

  logic                   found;
  logic [GRANT_WIDTH-1:0] sel;
  int                     idx;

  logic                   is_idle;
  logic                   is_hdr;
  logic                   is_pay;
  logic                   hdr_take;
  logic                   hdr_give;
  logic                   beat;
  logic                   last_beat;
  logic [15:0]            bc_inc;
  logic                   len_bad;

  assign is_idle = (state == IDLE);
  assign is_hdr  = (state == HEADER);
  assign is_pay  = (state == PAYLOAD);

  // Search starts just past the last served port, so it loses ties.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!found && in_hdr_valid[GRANT_WIDTH'(idx)]) begin
        found = 1'b1;
        sel   = GRANT_WIDTH'(idx);
      end
    end
  end

  assign hdr_take = is_idle && found;
  assign hdr_give = is_hdr && out_hdr_ready;

  always_comb begin
    in_hdr_ready = '0;
    if (hdr_take)
      in_hdr_ready[sel] = 1'b1;
  end

  assign out_tvalid = is_pay && in_tvalid[grant];
  assign out_tdata  = in_tdata[grant];
  assign out_tlast  = is_pay && in_tlast[grant];
  assign out_tuser  = is_pay && in_tuser[grant];

  always_comb begin
    in_tready = '0;
    if (is_pay)
      in_tready[grant] = out_tready;
  end

  assign beat      = out_tvalid && out_tready;
  assign last_beat = beat && out_tlast;

  assign bc_inc = (byte_count == 16'hFFFF) ?
                  byte_count : byte_count + 16'd1;

  // Header length covers the 8-byte UDP header plus payload.
  assign len_bad = (out_length < 16'd8) ||
                   (bc_inc != out_length - 16'd8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= GRANT_WIDTH'(NUM_PORTS - 1);
      grant        <= '0;
      busy         <= 1'b0;
      byte_count   <= '0;
      length_error <= 1'b0;
      error_port   <= '0;
    end else begin
      length_error <= 1'b0;
      unique case (1'b1)
        is_idle: begin
          if (hdr_take) begin
            grant      <= sel;
            byte_count <= '0;
            state      <= HEADER;
            busy       <= 1'b1;
          end
        end
        is_hdr: begin
          if (hdr_give)
            state <= PAYLOAD;
        end
        is_pay: begin
          if (beat)
            byte_count <= bc_inc;
          if (last_beat) begin
            if (len_bad) begin
              length_error <= 1'b1;
              error_port   <= grant;
            end
            rr_ptr <= grant;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_hdr_valid <= 1'b0;
      out_dscp      <= '0;
      out_ecn       <= '0;
      out_ttl       <= '0;
      out_src_ip    <= '0;
      out_dst_ip    <= '0;
      out_src_port  <= '0;
      out_dst_port  <= '0;
      out_length    <= '0;
      out_checksum  <= '0;
    end else if (hdr_take) begin
      out_hdr_valid <= 1'b1;
      out_dscp      <= in_dscp[sel];
      out_ecn       <= in_ecn[sel];
      out_ttl       <= in_ttl[sel];
      out_src_ip    <= in_src_ip[sel];
      out_dst_ip    <= in_dst_ip[sel];
      out_src_port  <= in_src_port[sel];
      out_dst_port  <= in_dst_port[sel];
      out_length    <= in_length[sel];
      out_checksum  <= in_checksum[sel];
    end else if (hdr_give) begin
      out_hdr_valid <= 1'b0;
    end
  end

endmodule
